// File: rtl/ps2_pkg.sv
// Shared types and helpers for the PS/2 host controller.
// Holds the line FSM states, the frame length and the microsecond-to-cycle conversion.
package ps2_pkg;

  typedef enum logic [2:0] {
    IDLE,
    RX,
    INHIBIT,
    REQ,
    TXB,
    ACK,
    WAITIDLE
  } ps2_state_e;

  localparam int FRAME_BITS = 11;

  // Whole-MHz clocks only; the fractional MHz part is dropped.
  function automatic int us_to_cyc(input int clk_hz, input int us);
    return (clk_hz / 1000000) * us;
  endfunction

endpackage

// File: rtl/ps2_line_filter.sv
// Conditions one async PS/2 pad: 2-flop synchronizer, FILT_LEN-sample level filter,
// and a one-cycle strobe in the first cycle the filtered level reads low after being high.
module ps2_line_filter #(
  parameter int FILT_LEN = 8
) (
  input  logic clk_i,
  input  logic rst_ni,
  input  logic pad_i,
  output logic level_o,
  output logic fe_o
);

  localparam int CW = $clog2(FILT_LEN + 1);

  logic [1:0]    sync_q;
  logic          filt_q, filt_d;
  logic          prev_q;
  logic [CW-1:0] cnt_q, cnt_d;

  // Any sample that agrees with the current level restarts the run count.
  always_comb begin
    filt_d = filt_q;
    cnt_d  = '0;
    if (sync_q[1] != filt_q) begin
      if (cnt_q == CW'(FILT_LEN - 1)) filt_d = sync_q[1];
      else                            cnt_d  = cnt_q + 1'b1;
    end
  end

  // Idle PS/2 lines are pulled high, so everything resets to 1.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      sync_q <= 2'b11;
      filt_q <= 1'b1;
      prev_q <= 1'b1;
      cnt_q  <= '0;
    end else begin
      sync_q <= {sync_q[0], pad_i};
      filt_q <= filt_d;
      prev_q <= filt_q;
      cnt_q  <= cnt_d;
    end
  end

  assign level_o = filt_q;
  assign fe_o    = prev_q & ~filt_q;

endmodule

// File: rtl/ps2_host_ctrl.sv
// PS/2 host line controller: receives device frames and sends host command frames,
// arbitrating the shared open-drain clock/data pair between the two directions.
import ps2_pkg::*;

module ps2_host_ctrl #(
  parameter int CLK_HZ     = 50000000,
  parameter int INHIBIT_US = 100,
  parameter int TIMEOUT_US = 2000,
  parameter int FILT_LEN   = 8
) (
  input  logic       CLK,
  input  logic       RST,
  input  logic       PS2_CLK_I,
  input  logic       PS2_DAT_I,
  output logic       PS2_CLK_OE,
  output logic       PS2_DAT_OE,
  input  logic [7:0] TX_DATA,
  input  logic       TX_VALID,
  output logic       TX_READY,
  output logic [7:0] RX_DATA,
  output logic       RX_VALID,
  output logic       RX_ERR,
  output logic       TX_ERR,
  output logic       TX_DONE
);

  localparam int INH_CYC = us_to_cyc(CLK_HZ, INHIBIT_US);
  localparam int TO_CYC  = us_to_cyc(CLK_HZ, TIMEOUT_US);
  localparam int CNT_MAX = (INH_CYC > TO_CYC) ? INH_CYC : TO_CYC;
  localparam int CNT_W   = $clog2(CNT_MAX + 1);

  logic clk_lvl, clk_fe, dat_lvl;

  ps2_line_filter #(.FILT_LEN(FILT_LEN)) u_clk_filt (
    .clk_i   (CLK),
    .rst_ni  (RST),
    .pad_i   (PS2_CLK_I),
    .level_o (clk_lvl),
    .fe_o    (clk_fe)
  );

  ps2_line_filter #(.FILT_LEN(FILT_LEN)) u_dat_filt (
    .clk_i   (CLK),
    .rst_ni  (RST),
    .pad_i   (PS2_DAT_I),
    .level_o (dat_lvl),
    .fe_o    ()
  );

  ps2_state_e       state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [3:0]       bit_q, bit_d;
  logic [9:0]       rx_sh_q, rx_sh_d;
  logic [9:0]       tx_frm_q, tx_frm_d;
  logic [7:0]       rx_data_q, rx_data_d;
  logic             rx_valid_q, rx_valid_d;
  logic             rx_err_q, rx_err_d;
  logic             tx_err_q, tx_err_d;
  logic             tx_done_q, tx_done_d;
  logic             clk_oe, dat_oe, ready, timeout;

  assign timeout = (cnt_q == CNT_W'(TO_CYC - 1));

  always_comb begin
    state_d    = state_q;
    cnt_d      = cnt_q + 1'b1;
    bit_d      = bit_q;
    rx_sh_d    = rx_sh_q;
    tx_frm_d   = tx_frm_q;
    rx_data_d  = rx_data_q;
    rx_valid_d = 1'b0;
    rx_err_d   = 1'b0;
    tx_err_d   = 1'b0;
    tx_done_d  = 1'b0;
    clk_oe     = 1'b0;
    dat_oe     = 1'b0;
    ready      = 1'b0;

    unique case (state_q)
      IDLE: begin
        ready = 1'b1;
        cnt_d = '0;
        bit_d = '0;
        // A command pre-empts a device frame that is just starting.
        if (TX_VALID) begin
          tx_frm_d = {1'b1, ~(^TX_DATA), TX_DATA};
          state_d  = INHIBIT;
        end else if (clk_fe) begin
          rx_sh_d = {dat_lvl, rx_sh_q[9:1]};
          bit_d   = 4'd1;
          state_d = RX;
        end
      end

      // rx_sh_q fills LSB-first: [0]=start, [8:1]=data, [9]=parity; stop is read live.
      RX: begin
        if (clk_fe) begin
          cnt_d = '0;
          if (bit_q == 4'd10) begin
            state_d = IDLE;
            if (!rx_sh_q[0] && (^rx_sh_q[9:1]) && dat_lvl) begin
              rx_valid_d = 1'b1;
              rx_data_d  = rx_sh_q[8:1];
            end else begin
              rx_err_d = 1'b1;
            end
          end else begin
            rx_sh_d = {dat_lvl, rx_sh_q[9:1]};
            bit_d   = bit_q + 4'd1;
          end
        end else if (timeout) begin
          rx_err_d = 1'b1;
          state_d  = IDLE;
        end
      end

      // Our own clock pull produces an edge here; it is deliberately ignored.
      INHIBIT: begin
        clk_oe = 1'b1;
        if (cnt_q == CNT_W'(INH_CYC - 1)) begin
          dat_oe  = 1'b1;
          cnt_d   = '0;
          state_d = REQ;
        end
      end

      REQ: begin
        dat_oe = 1'b1;
        if (clk_fe) begin
          cnt_d   = '0;
          bit_d   = '0;
          state_d = TXB;
        end else if (timeout) begin
          tx_err_d = 1'b1;
          state_d  = IDLE;
        end
      end

      TXB: begin
        dat_oe = ~tx_frm_q[bit_q];
        if (clk_fe) begin
          cnt_d = '0;
          if (bit_q == 4'd9) state_d = ACK;
          else               bit_d   = bit_q + 4'd1;
        end else if (timeout) begin
          tx_err_d = 1'b1;
          state_d  = IDLE;
        end
      end

      ACK: begin
        if (clk_fe) begin
          cnt_d     = '0;
          tx_done_d = ~dat_lvl;
          tx_err_d  = dat_lvl;
          state_d   = WAITIDLE;
        end else if (timeout) begin
          tx_err_d = 1'b1;
          state_d  = IDLE;
        end
      end

      WAITIDLE: begin
        if (clk_lvl && dat_lvl) begin
          state_d = IDLE;
        end else if (clk_fe) begin
          cnt_d = '0;
        end else if (timeout) begin
          tx_err_d = 1'b1;
          state_d  = IDLE;
        end
      end

      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge CLK or negedge RST) begin
    if (!RST) begin
      state_q    <= IDLE;
      cnt_q      <= '0;
      bit_q      <= '0;
      rx_sh_q    <= '0;
      tx_frm_q   <= '0;
      rx_data_q  <= '0;
      rx_valid_q <= 1'b0;
      rx_err_q   <= 1'b0;
      tx_err_q   <= 1'b0;
      tx_done_q  <= 1'b0;
    end else begin
      state_q    <= state_d;
      cnt_q      <= cnt_d;
      bit_q      <= bit_d;
      rx_sh_q    <= rx_sh_d;
      tx_frm_q   <= tx_frm_d;
      rx_data_q  <= rx_data_d;
      rx_valid_q <= rx_valid_d;
      rx_err_q   <= rx_err_d;
      tx_err_q   <= tx_err_d;
      tx_done_q  <= tx_done_d;
    end
  end

  // The state register already sits in IDLE during reset, so READY is gated by RST.
  assign TX_READY   = ready & RST;
  assign PS2_CLK_OE = clk_oe;
  assign PS2_DAT_OE = dat_oe;
  assign RX_DATA    = rx_data_q;
  assign RX_VALID   = rx_valid_q;
  assign RX_ERR     = rx_err_q;
  assign TX_ERR     = tx_err_q;
  assign TX_DONE    = tx_done_q;

endmodule

// File: doc/ps2_host_ctrl.md
Name: ps2_host_ctrl

Overview:
PS/2 host-side line controller for the board's PS/2 connector (keyboard/mouse). It receives device-to-host frames and sequences host-to-device command frames, such as keyboard LED set (0xED) and reset (0xFF). It arbitrates the shared clock/data line pair between the two directions. It sits between the top-level PS2_CLK/PS2_DAT open-drain pads and a Nios II-facing register/FIFO wrapper.

Parameters:
CLK_HZ, 50000000, system clock frequency in Hz
INHIBIT_US, 100, host clock-inhibit time before a TX request, in µs
TIMEOUT_US, 2000, maximum gap between PS/2 clock falling edges inside a frame, in µs
FILT_LEN, 8, consecutive equal samples required to accept a line level change

Ports:
CLK  in  1  system clock
RST  in  1  reset
PS2_CLK_I  in  1  PS/2 clock pad input (async)
PS2_DAT_I  in  1  PS/2 data pad input (async)
PS2_CLK_OE  out  1  1 = drive PS2_CLK low; 0 = release (pull-up)
PS2_DAT_OE  out  1  1 = drive PS2_DAT low; 0 = release
TX_DATA  in  8  command byte to send
TX_VALID  in  1  command request
TX_READY  out  1  controller can accept a command this cycle
RX_DATA  out  8  last received byte, held until the next valid frame
RX_VALID  out  1  one-cycle pulse: new RX_DATA
RX_ERR  out  1  one-cycle pulse: RX start/parity/stop/timeout error
TX_ERR  out  1  one-cycle pulse: TX no-ack/timeout error
TX_DONE  out  1  one-cycle pulse: device acknowledged command

Behaviour:
- Single clock CLK; RST is asynchronous, active-low.
- While RST=0 all outputs are 0, except TX_READY=0. State = IDLE. All counters cleared.
- Reset mid-frame abandons the frame silently: no error pulse, lines released.
- Input conditioning: 2-flop synchronizer, then a filter. The filtered level changes only after FILT_LEN consecutive samples that differ from it.
- Falling-edge strobe fe = 1 cycle after the filtered clock goes 1->0. Data is sampled from filtered data in the fe cycle.
- Frame format: start 0, D0..D7 LSB first, odd parity, stop 1 (11 bits).
- Timing constants: INH_CYC = CLK_HZ/1e6*INHIBIT_US; TO_CYC = CLK_HZ/1e6*TIMEOUT_US. Counter widths use $clog2.
- States:
  - IDLE: TX_READY=1, both OE=0.
    - TX_VALID=1 -> latch TX_DATA, compute parity, go INHIBIT.
    - Else fe -> go RX, with the sampled bit taken as the start bit.
    - TX_VALID and fe in the same cycle: TX wins. The host aborts the device frame; the device retransmits per protocol.
  - RX: bit counter 1..10 advances on each fe.
    - After bit 10 (stop): RX_VALID pulses in the following cycle if start=0, parity odd and stop=1; else RX_ERR pulses. Return to IDLE.
    - RX_DATA updates only on a valid frame.
  - INHIBIT: CLK_OE=1 for INH_CYC cycles. DAT_OE=1 in the last cycle. Go REQ.
  - REQ: CLK_OE=0, DAT_OE=1 (start bit). Wait for fe, go TXB.
  - TXB: on each fe, drive the next bit (D0..D7, parity, stop).
    - A bit value of 0 sets DAT_OE=1; a value of 1 sets DAT_OE=0. Stop sets DAT_OE=0.
    - After the fe that follows the stop bit, go ACK.
  - ACK: on the next fe, sample data. 0 -> TX_DONE pulse; 1 -> TX_ERR pulse. Go WAITIDLE.
  - WAITIDLE: wait until both filtered lines are 1, then go IDLE.
- TX_READY=0 in every state other than IDLE. TX_VALID is ignored while not ready.
- Timeout: in RX, REQ, TXB, ACK and WAITIDLE, a counter restarts on each fe.
  - Reaching TO_CYC pulses RX_ERR (in RX) or TX_ERR (all other states).
  - Both OE are released and the state returns to IDLE.
  - REQ measures timeout from state entry. INHIBIT has no timeout.
- Error and done pulses are mutually exclusive and last exactly one cycle.

Decomposition:
- Package ps2_pkg: state enum (IDLE, RX, INHIBIT, REQ, TXB, ACK, WAITIDLE), FRAME_BITS=11, and a function computing cycle counts from CLK_HZ and µs.
- Sub-module ps2_line_filter (synchronizer + FILT_LEN filter + falling-edge strobe), instantiated once per line. The data instance leaves its edge output unused.

Test Plan:
- Device model sends 0x1C, parity 0, bit period 80 µs -> one RX_VALID pulse, RX_DATA=0x1C, RX_ERR never high.
- Device sends 0x1C with parity bit 1 -> one RX_ERR pulse, no RX_VALID, RX_DATA holds its previous value.
- TX_VALID with TX_DATA=0xED at 50 MHz -> PS2_CLK_OE high for 5000 cycles, then device clocks out bits 1,0,1,1,0,1,1,1, parity 1, stop 1. Device ack=0 -> TX_DONE pulse, TX_READY returns to 1.
- Same command with the device never pulling data low in the ack slot -> TX_ERR pulse, both OE=0, state returns to IDLE.
- 3-cycle low glitch on PS2_CLK_I while IDLE -> no state change, no pulses.
- RST=0 after 5 received bits, then released and a full 0x5A frame sent -> all outputs 0 during reset, then RX_VALID with RX_DATA=0x5A.
